backbone_j_collect: RTL and testbench

//  Receive end of the backbone_J stream. The generator emits J-1 serial 64-bit doubles per backbone.

---
 rtl/backbone_j_collect.sv | 127 ++++++++++++
 tb/tb_backbone_j_collect.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/backbone_j_collect.sv
// Receive side of the backbone_J stream: packs J-1 serial doubles plus the backbone
// value into one J-slot vector and presents it with valid/ready handshake.
module backbone_j_collect #(
  parameter int J       = 14,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       backbone,
  input  logic              backbone_tvalid,
  input  logic [63:0]       backbone_J,
  input  logic              backbone_J_tvalid,
  input  logic              vec_tready,
  output logic [J*64-1:0]   backbone_J_vec,
  output logic              vec_tvalid,
  output logic [$clog2(J):0] beat_count,
  output logic              busy,
  output logic              err_orphan,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int DATA_W   = 64;
  localparam int J_WIDTH  = $clog2(J) + 1;
  localparam int TO_WIDTH = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t              state, state_nxt;
  logic [TO_WIDTH-1:0] idle_cnt;
  logic                arm, take_beat, last_beat, orphan, overrun, timeout, release_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Restart (backbone_tvalid) outranks beats in COLLECT; beats only land while collecting.
  always_comb begin
    state_nxt   = state;
    arm         = 1'b0;
    take_beat   = 1'b0;
    last_beat   = 1'b0;
    orphan      = 1'b0;
    overrun     = 1'b0;
    timeout     = 1'b0;
    release_vec = 1'b0;
    case (state)
      IDLE: begin
        orphan = backbone_J_tvalid;
        if (backbone_tvalid) begin
          arm       = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (backbone_tvalid) begin
          arm    = 1'b1;
          orphan = backbone_J_tvalid;
        end else if (backbone_J_tvalid) begin
          take_beat = 1'b1;
          if (beat_count == J_WIDTH'(J-1)) begin
            last_beat = 1'b1;
            state_nxt = HOLD;
          end
        end else if (idle_cnt == TO_WIDTH'(TIMEOUT-1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        orphan = backbone_J_tvalid;
        if (vec_tready) begin
          release_vec = 1'b1;
          if (backbone_tvalid) begin
            arm       = 1'b1;
            state_nxt = COLLECT;
          end else begin
            state_nxt = IDLE;
          end
        end else if (backbone_tvalid) begin
          overrun = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and payload; slots 1..J-1 are never cleared on restart or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      backbone_J_vec <= '0;
      vec_tvalid     <= 1'b0;
      beat_count     <= '0;
      busy           <= 1'b0;
      err_orphan     <= 1'b0;
      err_overrun    <= 1'b0;
      err_timeout    <= 1'b0;
      idle_cnt       <= '0;
    end else begin
      err_orphan  <= orphan;
      err_overrun <= overrun;
      err_timeout <= timeout;
      busy        <= (state_nxt != IDLE);

      if (arm) begin
        backbone_J_vec[0 +: DATA_W] <= backbone;
        beat_count                  <= J_WIDTH'(1);
        idle_cnt                    <= '0;
      end else if (take_beat) begin
        for (int j = 1; j < J; j++) begin
          if (beat_count == J_WIDTH'(j)) backbone_J_vec[j*DATA_W +: DATA_W] <= backbone_J;
        end
        beat_count <= beat_count + J_WIDTH'(1);
        idle_cnt   <= '0;
      end else if (timeout || release_vec) begin
        beat_count <= '0;
      end else if (state == COLLECT) begin
        idle_cnt <= idle_cnt + TO_WIDTH'(1);
      end

      if (last_beat)        vec_tvalid <= 1'b1;
      else if (release_vec) vec_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_backbone_j_collect.sv
// Directed bench for backbone_j_collect: J=14, TIMEOUT=8, hand-computed expectations.
module tb_backbone_j_collect;

  localparam int J       = 14;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [63:0]       backbone;
  logic              backbone_tvalid;
  logic [63:0]       backbone_J;
  logic              backbone_J_tvalid;
  logic              vec_tready;
  logic [J*64-1:0]   backbone_J_vec;
  logic              vec_tvalid;
  logic [4:0]        beat_count;
  logic              busy;
  logic              err_orphan;
  logic              err_overrun;
  logic              err_timeout;

  int n_vec  = 0;
  int n_miss = 0;

  backbone_j_collect #(.J(J), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .backbone(backbone), .backbone_tvalid(backbone_tvalid),
    .backbone_J(backbone_J), .backbone_J_tvalid(backbone_J_tvalid),
    .vec_tready(vec_tready), .backbone_J_vec(backbone_J_vec),
    .vec_tvalid(vec_tvalid), .beat_count(beat_count), .busy(busy),
    .err_orphan(err_orphan), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] slot(input int i);
    return backbone_J_vec[i*64 +: 64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [63:0] v);
    backbone        = v;
    backbone_tvalid = 1'b1;
    tick();
    backbone_tvalid = 1'b0;
  endtask

  task automatic beat(input logic [63:0] v);
    backbone_J        = v;
    backbone_J_tvalid = 1'b1;
    tick();
    backbone_J_tvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n             = 1'b0;
    backbone          = '0;
    backbone_tvalid   = 1'b0;
    backbone_J        = '0;
    backbone_J_tvalid = 1'b0;
    vec_tready        = 1'b0;
    repeat (3) tick();
    chk("rst_vec", 64'(|backbone_J_vec), 64'd0);
    chk("rst_tvalid", 64'(vec_tvalid), 64'd0);
    chk("rst_cnt", 64'(beat_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'({err_orphan, err_overrun, err_timeout}), 64'd0);
    rst_n = 1'b1;
    tick();

    // orphan beat from IDLE
    beat(64'h1111_2222_3333_4444);
    chk("orph_pulse", 64'(err_orphan), 64'd1);
    chk("orph_busy", 64'(busy), 64'd0);
    chk("orph_vec", 64'(|backbone_J_vec), 64'd0);
    tick();
    chk("orph_clear", 64'(err_orphan), 64'd0);

    // back-to-back burst
    arm(64'h3FF0_0000_0000_0000);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_cnt1", 64'(beat_count), 64'd1);
    for (int j = 1; j < J; j++) begin
      beat(64'h4000_0000_0000_0000 + 64'(j));
      if (j == 6)  chk("t1_cnt7", 64'(beat_count), 64'd7);
      if (j == 12) chk("t1_early", 64'(vec_tvalid), 64'd0);
    end
    chk("t1_tvalid", 64'(vec_tvalid), 64'd1);
    chk("t1_cnt14", 64'(beat_count), 64'd14);
    chk("t1_slot0", slot(0), 64'h3FF0_0000_0000_0000);
    for (int j = 1; j < J; j++) chk("t1_slot", slot(j), 64'h4000_0000_0000_0000 + 64'(j));
    vec_tready = 1'b1;
    tick();
    vec_tready = 1'b0;
    chk("t1_rel_tvalid", 64'(vec_tvalid), 64'd0);
    chk("t1_rel_busy", 64'(busy), 64'd0);
    chk("t1_rel_cnt", 64'(beat_count), 64'd0);

    // spaced beats, tready held low 10 cycles
    arm(64'h3FF8_0000_0000_0000);
    for (int j = 1; j < J; j++) begin
      beat(64'h5000_0000_0000_0000 + 64'(j));
      if (j < J-1) repeat (4) tick();
    end
    chk("t2_tvalid", 64'(vec_tvalid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2_hold_tvalid", 64'(vec_tvalid), 64'd1);
      chk("t2_hold_slot7", slot(7), 64'h5000_0000_0000_0007);
    end
    chk("t2_slot0", slot(0), 64'h3FF8_0000_0000_0000);
    vec_tready = 1'b1;
    tick();
    vec_tready = 1'b0;
    chk("t2_rel", 64'(vec_tvalid), 64'd0);

    // restart after 6 beats, coincident beat dropped
    arm(64'h4010_0000_0000_0000);
    for (int j = 1; j <= 6; j++) beat(64'h6000_0000_0000_0000 + 64'(j));
    chk("t4_cnt7", 64'(beat_count), 64'd7);
    backbone          = 64'h4020_0000_0000_0000;
    backbone_tvalid   = 1'b1;
    backbone_J        = 64'hDEAD_BEEF_DEAD_BEEF;
    backbone_J_tvalid = 1'b1;
    tick();
    backbone_tvalid   = 1'b0;
    backbone_J_tvalid = 1'b0;
    chk("t4_restart_cnt", 64'(beat_count), 64'd1);
    chk("t4_orphan", 64'(err_orphan), 64'd1);
    chk("t4_slot1_kept", slot(1), 64'h6000_0000_0000_0001);
    for (int j = 1; j < J; j++) beat(64'h7000_0000_0000_0000 + 64'(j));
    chk("t4_tvalid", 64'(vec_tvalid), 64'd1);
    chk("t4_slot0", slot(0), 64'h4020_0000_0000_0000);
    for (int j = 1; j < J; j++) chk("t4_slot", slot(j), 64'h7000_0000_0000_0000 + 64'(j));
    vec_tready = 1'b1;
    tick();
    vec_tready = 1'b0;

    // timeout after 4 beats
    arm(64'h0000_0000_0000_0001);
    for (int j = 1; j <= 4; j++) beat(64'h9000_0000_0000_0000 + 64'(j));
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      chk("t5_no_to", 64'(err_timeout), 64'd0);
    end
    chk("t5_busy_before", 64'(busy), 64'd1);
    tick();
    chk("t5_to", 64'(err_timeout), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_cnt", 64'(beat_count), 64'd0);
    chk("t5_tvalid", 64'(vec_tvalid), 64'd0);
    chk("t5_slot4", slot(4), 64'h9000_0000_0000_0004);
    tick();
    chk("t5_to_clear", 64'(err_timeout), 64'd0);

    // HOLD overrun, orphan, re-arm with tready, then async reset
    arm(64'h0000_0000_0000_AAAA);
    for (int j = 1; j < J; j++) beat(64'h8000_0000_0000_0000 + 64'(j));
    backbone        = 64'h0000_0000_0000_BBBB;
    backbone_tvalid = 1'b1;
    tick();
    backbone_tvalid = 1'b0;
    chk("t6_overrun", 64'(err_overrun), 64'd1);
    chk("t6_ovr_tvalid", 64'(vec_tvalid), 64'd1);
    chk("t6_ovr_slot0", slot(0), 64'h0000_0000_0000_AAAA);
    tick();
    chk("t6_ovr_clear", 64'(err_overrun), 64'd0);
    beat(64'h0000_0000_0000_CCCC);
    chk("t6_hold_orphan", 64'(err_orphan), 64'd1);
    chk("t6_hold_slot1", slot(1), 64'h8000_0000_0000_0001);
    backbone        = 64'h0000_0000_0000_DDDD;
    backbone_tvalid = 1'b1;
    vec_tready      = 1'b1;
    tick();
    backbone_tvalid = 1'b0;
    vec_tready      = 1'b0;
    chk("t6_rearm_tvalid", 64'(vec_tvalid), 64'd0);
    chk("t6_rearm_busy", 64'(busy), 64'd1);
    chk("t6_rearm_cnt", 64'(beat_count), 64'd1);
    chk("t6_rearm_slot0", slot(0), 64'h0000_0000_0000_DDDD);
    beat(64'h0000_0000_0000_1234);
    beat(64'h0000_0000_0000_5678);
    chk("t6_cnt3", 64'(beat_count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vec", 64'(|backbone_J_vec), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_cnt", 64'(beat_count), 64'd0);
    chk("t6_rst_tvalid", 64'(vec_tvalid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
